fetch_prefetch_unit: RTL and testbench
======================================

# fetch_prefetch_unit

Parametrised fetch control unit that streams multi-word instructions from the bus interface unit into a small prefetch FIFO. It sits between the BIU and decode. It fetches sequentially from a program counter and assembles BUS_W-wide bus words into INSTR_WORDS*BUS_W-bit instructions, each tagged with its PC. A branch redirect flushes all prefetched and in-flight work.

## Interface
- ADDR_W, 16, word address width
- BUS_W, 16, BIU data width
- INSTR_WORDS, 2, bus words per instruction (≥1)
- FIFO_DEPTH, 4, prefetch entries (power of 2, ≥2)
- RESET_PC, 0, PC after reset
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- redirect_valid  in  1  branch taken; flush and refetch
- redirect_pc  in  ADDR_W  branch target (instruction-aligned)
- mem_req  out  1  BIU read request
- mem_addr  out  ADDR_W  word address of request
- mem_ack  in  1  BIU read complete; mem_rdata valid this cycle
- mem_rdata  in  BUS_W  read data
- instr_valid  out  1  FIFO head valid
- instr  out  INSTR_WORDS*BUS_W  assembled instruction
- instr_pc  out  ADDR_W  address of the instruction's first word
- instr_ready  in  1  decode accepts head
- busy  out  1  request outstanding or draining

## Operation
- FSM states:
  - IDLE: one cycle after reset, then FETCH.
  - FETCH: mem_req=1, mem_addr=pc.
  - STALL: FIFO full or insufficient space.
  - DRAIN: redirect while a request is outstanding.
- Word order: the first word fetched goes to the MSBs (instr[top -: BUS_W]); later words fill downward.
- On mem_ack in FETCH:
  - store the word and increment pc by 1 (wrap mod 2^ADDR_W).
  - After the last word, push {instr, start PC} into the FIFO and clear the word count.
- Flow control:
  - A new instruction starts only if free entries ≥1, counting any partially assembled entry.
  - Otherwise go to STALL; leave STALL the cycle after a pop frees space.
- Request rule: at most one request outstanding. mem_req and mem_addr stay stable until mem_ack is sampled high.
- Redirect:
  - Flush the FIFO, clear the word count, set pc=redirect_pc and start_pc=redirect_pc.
  - If mem_req is high without ack that cycle, go to DRAIN. Wait for mem_ack, discard the data, then go to FETCH.
- Simultaneous events:
  - redirect with mem_ack: data discarded; next request at redirect_pc next cycle.
  - redirect with pop: flush wins; the pop has no effect beyond the flush.
  - push with pop when full: both occur.
  - redirect during DRAIN: update the target and stay in DRAIN.
- Reset mid-transaction: all state cleared. A late mem_ack after reset is ignored in IDLE.

## Timing
- Reset values:
  - mem_req=0, mem_addr=0, instr_valid=0, instr=0, instr_pc=0, busy=0.
  - pc=RESET_PC, state IDLE.
- mem_req asserts in the 2nd cycle after reset deasserts.
- Zero-wait BIU: one word per cycle. instr_valid rises the cycle after the last word's mem_ack.
- instr, instr_pc and instr_valid are registered FIFO outputs. The head updates the cycle after an accepted pop (instr_valid & instr_ready).
- Redirect to first request at the target: 1 cycle if no request is outstanding, otherwise ack+1.
- busy = mem_req | (state==DRAIN).

## Configuration
- FETCH_PERF_CNT_EN defined:
  - adds outputs perf_fetched (32 bits, instructions pushed) and perf_flushed (32 bits, valid entries plus partial entries discarded by redirects).
  - Both counters are saturating and zeroed on reset.
- Not defined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- fetch_pkg holds:
  - the state enum (IDLE, FETCH, STALL, DRAIN)
  - default parameter constants
  - the INSTR_W = INSTR_WORDS*BUS_W helper
- Sub-module fetch_fifo: a synchronous FIFO of {instr, pc} entries. It has push, pop, flush, full, empty and a count output, and is parameterised by width and depth.
- The FSM, word assembler and PC logic live in the top level.

## Test plan
- Reset, RESET_PC=0x0010, zero-wait BIU, rdata=addr -> requests at 0x10,0x11,0x12,…; first instr=0x0010_0011 with instr_pc=0x0010.
- instr_ready=0, FIFO_DEPTH=4 -> exactly 8 acks then mem_req=0 (STALL). One pop -> mem_req resumes the next cycle.
- BIU 3-cycle wait states -> mem_addr stable across the wait; one instruction every 6 cycles.
- redirect_valid to 0x0200 while request at 0x0013 is pending -> DRAIN; ack data dropped; next request 0x0200; FIFO empty; instr_pc=0x0200.
- pc=0xFFFF, INSTR_WORDS=2 -> words from 0xFFFF, 0x0000; instr_pc=0xFFFF.
- FETCH_PERF_CNT_EN: 5 instructions fetched, then a redirect with 2 queued plus 1 partial -> perf_fetched=5, perf_flushed=3.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared state encoding, default parameters and width helper for the fetch/prefetch unit.
package fetch_pkg;

  localparam int unsigned DEF_ADDR_W      = 16;
  localparam int unsigned DEF_BUS_W       = 16;
  localparam int unsigned DEF_INSTR_WORDS = 2;
  localparam int unsigned DEF_FIFO_DEPTH  = 4;
  localparam int unsigned PERF_W          = 32;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    STALL,
    DRAIN
  } fetch_state_e;

  function automatic int unsigned instr_w(input int unsigned words, input int unsigned bus_w);
    return words * bus_w;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Shift-register prefetch FIFO of {instr, pc} entries; slot 0 is always the head,
// so the read data, valid and status outputs all come straight from flops.
module fetch_fifo #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             valid_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d, wr_idx_c;
  logic             valid_q, full_q, empty_q;
  logic             do_push_c, do_pop_c;

  assign do_pop_c  = pop_i & (count_q != '0);
  assign do_push_c = push_i & ((count_q != CNT_W'(DEPTH)) | do_pop_c);
  assign wr_idx_c  = count_q - CNT_W'(do_pop_c);

  // Pop shifts everything toward the head; a push lands behind the last survivor.
  always_comb begin
    data_d  = data_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      if (do_pop_c) begin
        for (int i = 0; i < int'(DEPTH) - 1; i++) data_d[i] = data_q[i+1];
      end
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (do_push_c && (wr_idx_c == CNT_W'(i))) data_d[i] = wdata_i;
      end
      count_d = count_q + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) data_q[i] <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
      valid_q <= (count_d != '0);
      full_q  <= (count_d == CNT_W'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  assign rdata_o = data_q[0];
  assign valid_o = valid_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = count_q;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Sequential instruction fetcher: assembles bus words into instructions and queues them for decode.
// Optional saturating perf counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W      = DEF_ADDR_W,
  parameter int unsigned       BUS_W       = DEF_BUS_W,
  parameter int unsigned       INSTR_WORDS = DEF_INSTR_WORDS,
  parameter int unsigned       FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  localparam int unsigned      INSTR_W     = instr_w(INSTR_WORDS, BUS_W)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [BUS_W-1:0]   mem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready,
`ifdef FETCH_PERF_CNT_EN
  output logic [PERF_W-1:0]  perf_fetched,
  output logic [PERF_W-1:0]  perf_flushed,
`endif
  output logic               busy
);

  localparam int unsigned ENTRY_W = INSTR_W + ADDR_W;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned WCNT_W  = (INSTR_WORDS > 1) ? $clog2(INSTR_WORDS) : 1;

  fetch_state_e        state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d, start_pc_q, start_pc_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [INSTR_W-1:0]  asm_q, asm_d, asm_fill_c;
  logic                mem_req_q, mem_req_d, busy_q, busy_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                push_c, pop_c, last_c, room_c;
  logic [ADDR_W-1:0]   push_pc_c;
  logic [CNT_W-1:0]    occ_c;
  logic [ENTRY_W-1:0]  fifo_rdata;
  logic                fifo_valid, fifo_full, fifo_empty;
  logic [CNT_W-1:0]    fifo_count;

  // Incoming word lands in its slot; the first word of an instruction occupies the MSBs.
  for (genvar g = 0; g < INSTR_WORDS; g++) begin : g_word
    assign asm_fill_c[(INSTR_WORDS-1-g)*BUS_W +: BUS_W] =
      (wcnt_q == WCNT_W'(g)) ? mem_rdata : asm_q[(INSTR_WORDS-1-g)*BUS_W +: BUS_W];
  end

  assign last_c    = (wcnt_q == WCNT_W'(INSTR_WORDS - 1));
  assign push_pc_c = (wcnt_q == '0) ? pc_q : start_pc_q;
  assign pop_c     = instr_ready & ~fifo_empty & ~redirect_valid;
  assign occ_c     = fifo_count + CNT_W'(1) - CNT_W'(pop_c);
  assign room_c    = (occ_c < CNT_W'(FIFO_DEPTH));

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    start_pc_d = start_pc_q;
    wcnt_d     = wcnt_q;
    asm_d      = asm_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    push_c     = 1'b0;
    if (redirect_valid) begin
      pc_d       = redirect_pc;
      start_pc_d = redirect_pc;
      wcnt_d     = '0;
      // An unacknowledged request must complete before the new target can be issued.
      if (mem_req_q && !mem_ack) begin
        state_d = DRAIN;
      end else begin
        state_d    = FETCH;
        mem_req_d  = 1'b1;
        mem_addr_d = redirect_pc;
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_d    = FETCH;
          mem_req_d  = 1'b1;
          mem_addr_d = pc_q;
        end
        FETCH: begin
          if (mem_req_q && mem_ack) begin
            asm_d = asm_fill_c;
            pc_d  = pc_q + ADDR_W'(1);
            if (wcnt_q == '0) start_pc_d = pc_q;
            if (last_c) begin
              push_c = 1'b1;
              wcnt_d = '0;
              if (room_c) begin
                mem_addr_d = pc_q + ADDR_W'(1);
              end else begin
                state_d   = STALL;
                mem_req_d = 1'b0;
              end
            end else begin
              wcnt_d     = wcnt_q + WCNT_W'(1);
              mem_addr_d = pc_q + ADDR_W'(1);
            end
          end
        end
        STALL: begin
          if (pop_c || !fifo_full) begin
            state_d    = FETCH;
            mem_req_d  = 1'b1;
            mem_addr_d = pc_q;
          end
        end
        DRAIN: begin
          if (mem_ack) begin
            state_d    = FETCH;
            mem_req_d  = 1'b1;
            mem_addr_d = pc_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = mem_req_d | (state_d == DRAIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      start_pc_q <= RESET_PC;
      wcnt_q     <= '0;
      asm_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      start_pc_q <= start_pc_d;
      wcnt_q     <= wcnt_d;
      asm_q      <= asm_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      busy_q     <= busy_d;
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .flush_i (redirect_valid),
    .wdata_i ({asm_fill_c, push_pc_c}),
    .rdata_o (fifo_rdata),
    .valid_o (fifo_valid),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign busy        = busy_q;
  assign instr_valid = fifo_valid;
  assign instr       = fifo_rdata[ENTRY_W-1 -: INSTR_W];
  assign instr_pc    = fifo_rdata[ADDR_W-1:0];

`ifdef FETCH_PERF_CNT_EN
  localparam int unsigned SUM_W = PERF_W + 1;
  logic [PERF_W-1:0] fetched_q, flushed_q;
  logic [SUM_W-1:0]  flushed_sum_c;

  // Queued entries plus a partially assembled one are all lost on a redirect.
  assign flushed_sum_c = SUM_W'(flushed_q) + SUM_W'(fifo_count) + SUM_W'(wcnt_q != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      fetched_q <= '0;
      flushed_q <= '0;
    end else begin
      if (push_c && (fetched_q != '1)) fetched_q <= fetched_q + PERF_W'(1);
      if (redirect_valid) flushed_q <= flushed_sum_c[PERF_W] ? '1 : flushed_sum_c[PERF_W-1:0];
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_flushed = flushed_q;
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit: BIU model with wait states/hold, scoreboard of assembled instructions.
module tb_fetch_prefetch_unit;

  localparam int unsigned ADDR_W      = 16;
  localparam int unsigned BUS_W       = 16;
  localparam int unsigned INSTR_WORDS = 2;
  localparam int unsigned FIFO_DEPTH  = 4;
  localparam int unsigned INSTR_W     = INSTR_WORDS * BUS_W;
  localparam logic [ADDR_W-1:0] RST_PC = 16'h0010;

  logic clk = 1'b0;
  logic reset, redirect_valid, mem_req, mem_ack, instr_valid, instr_ready, busy;
  logic [ADDR_W-1:0]  redirect_pc, mem_addr, instr_pc;
  logic [BUS_W-1:0]   mem_rdata;
  logic [INSTR_W-1:0] instr;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_flushed;
`endif

  always #5 clk = ~clk;

  fetch_prefetch_unit #(
    .ADDR_W(ADDR_W), .BUS_W(BUS_W), .INSTR_WORDS(INSTR_WORDS),
    .FIFO_DEPTH(FIFO_DEPTH), .RESET_PC(RST_PC)
  ) dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched(perf_fetched), .perf_flushed(perf_flushed),
`endif
    .busy(busy)
  );

  // BIU: data = address, ack on the lat-th cycle of a request, optional hold on one address.
  int unsigned       lat = 1;
  int unsigned       wait_cnt = 0;
  logic              hold_en = 1'b0;
  logic [ADDR_W-1:0] hold_addr = '0;
  assign mem_ack   = mem_req && !(hold_en && (mem_addr == hold_addr)) && (wait_cnt + 1 >= lat);
  assign mem_rdata = mem_addr;
  always @(posedge clk) wait_cnt <= (mem_req && !mem_ack) ? wait_cnt + 1 : 0;

  int checks = 0;
  int failures = 0;
  logic [INSTR_W+ADDR_W-1:0] sb_q[$];
  logic [INSTR_W-1:0] part;
  logic [ADDR_W-1:0]  part_pc;
  int part_n = 0;
  logic drop = 1'b0;
  int cyc_n = 0, last_push = 0, push_gap = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: update the reference model from this cycle's inputs/outputs, then advance.
  task automatic cyc();
    logic [INSTR_W+ADDR_W-1:0] e;
    if (reset) begin
      sb_q.delete(); part_n = 0; drop = 1'b0;
    end else if (redirect_valid) begin
      sb_q.delete(); part_n = 0;
      drop = mem_req && !mem_ack;
    end else begin
      if (instr_valid && instr_ready) begin
        if (sb_q.size() == 0) check("sb_unexpected_valid", 64'(instr_valid), 64'd0);
        else begin
          e = sb_q.pop_front();
          check("sb_instr", 64'(instr), 64'(e[INSTR_W+ADDR_W-1:ADDR_W]));
          check("sb_pc", 64'(instr_pc), 64'(e[ADDR_W-1:0]));
        end
      end
      if (mem_req && mem_ack) begin
        if (drop) drop = 1'b0;
        else begin
          if (part_n == 0) part_pc = mem_addr;
          part = (part << BUS_W) | INSTR_W'(mem_rdata);
          part_n++;
          if (part_n == int'(INSTR_WORDS)) begin
            sb_q.push_back({part, part_pc});
            part_n = 0;
            push_gap = cyc_n - last_push;
            last_push = cyc_n;
          end
        end
      end
    end
    @(posedge clk); #1;
    cyc_n++;
  endtask

  initial begin
    int acks;
    logic pr, pa;
    logic [ADDR_W-1:0] paddr;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    repeat (3) cyc();
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_instr_valid", 64'(instr_valid), 64'd0);
    check("rst_instr", 64'(instr), 64'd0);
    check("rst_instr_pc", 64'(instr_pc), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    check("idle_no_req", 64'(mem_req), 64'd0);
    cyc();
    check("first_req", 64'(mem_req), 64'd1);
    check("first_addr", 64'(mem_addr), 64'h0010);

    // Zero-wait stream with decode stalled: four instructions fill the FIFO.
    acks = 0;
    for (int i = 0; i < 16; i++) begin
      if (mem_req && mem_ack) begin
        check("stream_addr", 64'(mem_addr), 64'(ADDR_W'(RST_PC + ADDR_W'(acks))));
        acks++;
      end
      cyc();
    end
    check("acks_before_stall", 64'(acks), 64'd8);
    check("stall_no_req", 64'(mem_req), 64'd0);
    check("stall_not_busy", 64'(busy), 64'd0);
    check("head_valid", 64'(instr_valid), 64'd1);
    check("head_instr", 64'(instr), 64'h0010_0011);
    check("head_pc", 64'(instr_pc), 64'h0010);

    // Single pop releases the stall on the next cycle.
    instr_ready = 1'b1;
    cyc();
    instr_ready = 1'b0;
    check("resume_req", 64'(mem_req), 64'd1);
    check("resume_addr", 64'(mem_addr), 64'h0018);
    check("head_after_pop", 64'(instr_pc), 64'h0012);
    repeat (8) cyc();
    check("restall_no_req", 64'(mem_req), 64'd0);

    // Three-cycle BIU: address must hold during the wait, one instruction per six cycles.
    lat = 3; instr_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      pr = mem_req; pa = mem_ack; paddr = mem_addr;
      cyc();
      if (pr && !pa && mem_req) check("wait_addr_stable", 64'(mem_addr), 64'(paddr));
    end
    check("instr_period", 64'(push_gap), 64'd6);

    // Redirect while the request at 0x0013 is pending.
    lat = 1; hold_en = 1'b1; hold_addr = 16'h0013;
    redirect_valid = 1'b1; redirect_pc = 16'h0012;
    cyc();
    redirect_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req && mem_addr == 16'h0013) break;
      cyc();
    end
    check("pend_addr", 64'(mem_addr), 64'h0013);
    cyc();
    redirect_valid = 1'b1; redirect_pc = 16'h0200;
    cyc();
    redirect_valid = 1'b0;
    check("drain_busy", 64'(busy), 64'd1);
    check("drain_req_held", 64'(mem_req), 64'd1);
    check("drain_addr_held", 64'(mem_addr), 64'h0013);
    check("flush_empty", 64'(instr_valid), 64'd0);
    hold_en = 1'b0;
    cyc();
    check("target_req", 64'(mem_req), 64'd1);
    check("target_addr", 64'(mem_addr), 64'h0200);
    for (int i = 0; i < 10; i++) begin
      if (instr_valid) break;
      cyc();
    end
    check("target_instr", 64'(instr), 64'h0200_0201);
    check("target_pc", 64'(instr_pc), 64'h0200);

    // PC wrap across the top of the address space.
    instr_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
    cyc();
    redirect_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (instr_valid) break;
      cyc();
    end
    check("wrap_instr", 64'(instr), 64'hFFFF_0000);
    check("wrap_pc", 64'(instr_pc), 64'hFFFF);
    repeat (10) cyc();

    // Reset mid-stream, then five fetched and a redirect with two queued plus one partial.
    reset = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;
    check("rst2_req", 64'(mem_req), 64'd0);
    check("rst2_valid", 64'(instr_valid), 64'd0);
    hold_en = 1'b1; hold_addr = 16'h001B;
    repeat (13) cyc();
    check("perf_stall", 64'(mem_req), 64'd0);
    instr_ready = 1'b1;
    repeat (3) cyc();
    instr_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (mem_req && mem_addr == 16'h001B) break;
      cyc();
    end
    check("partial_pend", 64'(mem_addr), 64'h001B);
    check("queued_valid", 64'(instr_valid), 64'd1);
    redirect_valid = 1'b1; redirect_pc = 16'h0040;
    cyc();
    redirect_valid = 1'b0;
    check("flush2_empty", 64'(instr_valid), 64'd0);
    check("flush2_drain", 64'(busy), 64'd1);
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetched", 64'(perf_fetched), 64'd5);
    check("perf_flushed", 64'(perf_flushed), 64'd3);
`endif
    hold_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (instr_valid) break;
      cyc();
    end
    check("after_flush_pc", 64'(instr_pc), 64'h0040);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
